// File: rtl/audio_adc_deserializer.sv
// Serial audio ADC receiver: oversamples BCLK/LRCK/DAT in the clk domain and
// rebuilds signed left/right words with one-cycle valid strobes per channel.
module audio_adc_deserializer #(
    parameter int AUDIO_DATA_WIDTH = 24,
    parameter bit I2S_MODE         = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        adc_bclk,
    input  logic                        adc_lrck,
    input  logic                        adc_dat,
    input  logic                        clear_error,
    output logic [AUDIO_DATA_WIDTH-1:0] left_data,
    output logic [AUDIO_DATA_WIDTH-1:0] right_data,
    output logic                        left_valid,
    output logic                        right_valid,
    output logic                        frame_error
);

    localparam int W  = AUDIO_DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LP_W_CNT = CW'(W);

    typedef enum logic [1:0] {WAIT_SYNC, SKIP, SHIFT, HOLD} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_bclk_s1, r_bclk_s2, r_bclk_d;
    logic          r_lrck_s1, r_lrck_s2, r_dat_s1, r_dat_s2;
    logic          r_lrck_prev, r_lrck_seen, r_chan;
    logic [W-1:0]  r_shreg;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_bclk_rise, w_lrck_edge, w_lrck_chan, w_chan_nxt;
    logic          w_shift, w_done, w_err_set;
    logic [W-1:0]  w_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bclk_s1 <= 1'b0; r_bclk_s2 <= 1'b0; r_bclk_d <= 1'b0;
            r_lrck_s1 <= 1'b0; r_lrck_s2 <= 1'b0;
            r_dat_s1  <= 1'b0; r_dat_s2  <= 1'b0;
        end else begin
            r_bclk_s1 <= adc_bclk;  r_bclk_s2 <= r_bclk_s1; r_bclk_d <= r_bclk_s2;
            r_lrck_s1 <= adc_lrck;  r_lrck_s2 <= r_lrck_s1;
            r_dat_s1  <= adc_dat;   r_dat_s2  <= r_dat_s1;
        end
    end

    assign w_bclk_rise = r_bclk_s2 & ~r_bclk_d;
    // The first LRCK sample after reset only primes the history, so a
    // mid-slot release can never be mistaken for a word boundary.
    assign w_lrck_edge = r_lrck_seen & (r_lrck_s2 != r_lrck_prev);
    assign w_lrck_chan = I2S_MODE ? ~r_lrck_s2 : r_lrck_s2;
    assign w_chan_nxt  = w_lrck_edge ? w_lrck_chan : r_chan;
    assign w_word      = {r_shreg[W-2:0], r_dat_s2};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= WAIT_SYNC;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_err_set   = 1'b0;
        if (w_bclk_rise) begin
            if (w_lrck_edge) begin
                if (r_state == SKIP || r_state == SHIFT) w_err_set = 1'b1;
                if (I2S_MODE) begin
                    w_state_nxt = SKIP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = SHIFT;
                    w_shift     = 1'b1;
                    w_cnt_nxt   = CW'(1);
                end
            end else if (r_state == SKIP || r_state == SHIFT) begin
                // The bit after the I2S delay slot is already the MSB.
                w_state_nxt = SHIFT;
                w_shift     = 1'b1;
                w_cnt_nxt   = (r_state == SKIP) ? CW'(1) : r_cnt + CW'(1);
            end
            if (w_shift && w_cnt_nxt == LP_W_CNT) begin
                w_done      = 1'b1;
                w_state_nxt = HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lrck_prev <= 1'b0;
            r_lrck_seen <= 1'b0;
            r_chan      <= 1'b0;
            r_cnt       <= '0;
            r_shreg     <= '0;
            left_data   <= '0;
            right_data  <= '0;
            left_valid  <= 1'b0;
            right_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            left_valid  <= 1'b0;
            right_valid <= 1'b0;
            r_cnt       <= w_cnt_nxt;
            r_chan      <= w_chan_nxt;
            if (w_bclk_rise) begin
                r_lrck_prev <= r_lrck_s2;
                r_lrck_seen <= 1'b1;
            end
            if (w_shift) r_shreg <= w_word;
            if (w_done) begin
                if (w_chan_nxt) begin
                    left_data  <= w_word;
                    left_valid <= 1'b1;
                end else begin
                    right_data  <= w_word;
                    right_valid <= 1'b1;
                end
            end
            if (w_err_set)        frame_error <= 1'b1;
            else if (clear_error) frame_error <= 1'b0;
        end
    end

endmodule
